// File: rtl/uart_rx_if.sv
// uart_rx_if: serial RX line plus the receiver's status/data outputs.
// slave  - the receiver end (uart_rx)
// master - the side driving the line and consuming received bytes
interface uart_rx_if;
   logic       uart_rxd;
   logic       uart_rx_busy;
   logic       uart_done;
   logic [7:0] uart_data;
   logic       frame_err;

   modport master (
      output uart_rxd,
      input  uart_rx_busy, uart_done, uart_data, frame_err
   );

   modport slave (
      input  uart_rxd,
      output uart_rx_busy, uart_done, uart_data, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Three-flop synchroniser, falling-edge start
// detect, centre sampling of every bit, one-cycle uart_done / frame_err.
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   - 2-of-3 vote over clk_cnt = MID-1, MID, MID+1; decision at MID+1
//   undefined - single sample at clk_cnt = MID; decision at MID
// The FSM leaves STOP at the decision point (mid stop bit) so a slightly
// short stop bit from the transmitter still lets the next start edge land
// while we are already back in IDLE.
module uart_rx #(
   parameter int CLK_FREQ = 36000000,
   parameter int UART_BPS = 9600
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_rx_if.slave    bus
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int MID     = BPS_CNT / 2;

   localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
   localparam logic [15:0] CNT_MID = 16'(MID);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] CNT_PRE = 16'(MID - 1);
   localparam logic [15:0] CNT_DEC = 16'(MID + 1);
`else
   localparam logic [15:0] CNT_DEC = 16'(MID);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic        rxd_s1, rxd_s2, rxd_s3;
   logic [15:0] clk_cnt, cnt_nx;
   logic [2:0]  bit_cnt, bit_nx;
   logic [7:0]  shift, shift_nx;
   logic [7:0]  data_q, data_nx;
   logic        done_q, done_nx;
   logic        ferr_q, ferr_nx;
   logic        start_edge;
   logic        at_dec;
   logic        bit_smp;

   // Falling edge seen through the synchroniser. A line held low never
   // re-arms this, so a break condition yields a single frame_err.
   assign start_edge = rxd_s3 & ~rxd_s2;
   assign at_dec     = (clk_cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote;

   // Capture the two early votes; the third is the live sample at MID+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vote <= 2'b00;
      end else if (state != IDLE) begin
         if (clk_cnt == CNT_PRE) vote[0] <= rxd_s2;
         if (clk_cnt == CNT_MID) vote[1] <= rxd_s2;
      end
   end

   assign bit_smp = (vote[0] & vote[1]) | (vote[0] & rxd_s2) | (vote[1] & rxd_s2);
`else
   // Single centre sample; CNT_MID doubles as the decision point here.
   assign bit_smp = rxd_s2;
`endif

   // Synchroniser for the asynchronous line; resets to the idle (high) level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_s3 <= 1'b1;
      end else begin
         rxd_s1 <= bus.uart_rxd;
         rxd_s2 <= rxd_s1;
         rxd_s3 <= rxd_s2;
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         clk_cnt <= cnt_nx;
         bit_cnt <= bit_nx;
         shift   <= shift_nx;
         data_q  <= data_nx;
         done_q  <= done_nx;
         ferr_q  <= ferr_nx;
      end
   end

   // Next-state and datapath updates; pulses default low every cycle.
   always_comb begin
      state_nx = state;
      cnt_nx   = clk_cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      data_nx  = data_q;
      done_nx  = 1'b0;
      ferr_nx  = 1'b0;

      if (state != IDLE)
         cnt_nx = (clk_cnt == CNT_MAX) ? '0 : clk_cnt + 16'd1;

      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nx = START;
               cnt_nx   = '0;
            end
         end
         START: begin
            if (at_dec && bit_smp) begin
               // Line back high at the centre: glitch, not a start bit.
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (clk_cnt == CNT_MAX) begin
               state_nx = DATA;
               bit_nx   = '0;
            end
         end
         DATA: begin
            if (at_dec)
               shift_nx[bit_cnt] = bit_smp;
            if (clk_cnt == CNT_MAX) begin
               bit_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_nx = STOP;
            end
         end
         STOP: begin
            if (at_dec) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               if (bit_smp) begin
                  data_nx = shift;
                  done_nx = 1'b1;
               end else begin
                  ferr_nx = 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign bus.uart_rx_busy = (state != IDLE);
   assign bus.uart_done    = done_q;
   assign bus.frame_err    = ferr_q;
   assign bus.uart_data    = data_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive block: the receiving end of the team's 8N1 serial link, paired with `uart_tx`. It synchronises the asynchronous `uart_rxd` line and detects the start-bit falling edge. Each bit is sampled at its centre, and the block delivers one byte per frame as a single-cycle `uart_done` pulse together with `uart_data`. It sits between the board RX pin and the command/data consumer logic.

## Interface
- `CLK_FREQ`, 36000000, system clock frequency in Hz
- `UART_BPS`, 9600, baud rate
- `BPS_CNT` (localparam), CLK_FREQ/UART_BPS, clocks per bit; the legal range is 4..65535
- `MID` (localparam), BPS_CNT/2, the bit-centre count
- `clk` input 1: system clock
- `rst_n` input 1: reset, synchronous, active-low
- `uart_rxd` input 1: serial line, asynchronous, idles high
- `uart_rx_busy` output 1: high while a frame is in progress
- `uart_done` output 1: one-cycle pulse when a valid byte is received
- `uart_data` output 8: last valid received byte
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low

## Operation
- **Synchroniser.** `uart_rxd` passes through three flops: `rxd_s1`, `rxd_s2`, `rxd_s3`.
  - Start edge condition: `rxd_s3==1 && rxd_s2==0`, evaluated only in IDLE.
- **Bit counter.** `clk_cnt` is 16 bits wide.
  - It counts 0..BPS_CNT-1 within each bit period and wraps to 0.
  - It is cleared on entry to START.
  - `bit_cnt` is 3 bits wide and indexes the data bits.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on the start edge; `clk_cnt`=0.
  - START: at the decision point, if the sampled bit is 1 (false start, glitch), go to IDLE with no pulse. Otherwise continue.
  - START → DATA at `clk_cnt`==BPS_CNT-1; `bit_cnt`=0.
  - DATA: at the decision point, the sampled bit is shifted in LSB-first (`shift[bit_cnt]`).
  - DATA: at `clk_cnt`==BPS_CNT-1, `bit_cnt` increments. After bit 7, go to STOP.
  - STOP: at the decision point, if the bit is 1, `uart_data`←shift and `uart_done` is pulsed. If the bit is 0, `frame_err` is pulsed and `uart_data` is unchanged.
  - STOP → IDLE at that same decision point. The block does not wait for the end of the stop bit, which gives resync margin against `uart_tx` stop-bit trimming.
- **Busy and start detection.**
  - `uart_rx_busy` = (state != IDLE).
  - Start edges during a frame are ignored.
- **Break / stuck-low line.** After `frame_err`, no new frame starts until `rxd_s2` has been seen high and then falls. The edge-detect rule enforces this; a line held low yields exactly one `frame_err`.
- **Output registers.**
  - `uart_done` and `frame_err` are registered and never high together.
  - Each is high for exactly one clock.
- **Reset** (synchronous, overrides everything, including mid-frame):
  - state=IDLE, counters=0, shift=0, sync flops=1.
  - `uart_data`=0, `uart_done`=0, `frame_err`=0, `uart_rx_busy`=0.
  - A frame aborted by reset produces no pulse.

## Timing
- **Synchroniser latency.** A falling edge on `uart_rxd` captured at clock edge k appears at `rxd_s2` at edge k+1. The FSM enters START at edge k+2, so `uart_rx_busy`=1 from edge k+2.
- **Decision point** (D), counted in each bit period:
  - D = `MID`+1 with the majority-vote macro.
  - D = `MID` without it.
- **Done/error latency.** `uart_done`/`frame_err` go high on the clock edge after `clk_cnt`==D in STOP. On that same edge `uart_rx_busy` drops.
  - Frame latency from START entry to the pulse = 9·BPS_CNT + D + 1 clocks.
- **Output hold.** `uart_data` changes only on the `uart_done` edge and holds until the next valid frame.
- **Back-to-back frames.** A start edge arriving in the cycle immediately after the return to IDLE is accepted, so back-to-back frames are supported.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:** each bit (start, data, stop) is sampled at `clk_cnt` = MID-1, MID and MID+1. The bit value is the 2-of-3 majority, and D = MID+1.
- **Undefined:** a single sample is taken at `clk_cnt`==MID, and D = MID. The majority logic is absent.
- **Unaffected by the macro:** all state transitions and the pulse rules.

## Test plan
Bench parameters: CLK_FREQ=160000 and UART_BPS=10000, giving BPS_CNT=16 and MID=8.
- **Clean byte.** Drive 0xA5 (8N1, 16 clocks/bit), line idle high → one `uart_done` pulse with `uart_data`=0xA5, `frame_err`=0; busy high for 9·16+D+1 clocks.
- **Back-to-back.** Send 0x00 then 0xFF with no idle gap → two `uart_done` pulses; `uart_data` = 0x00, then 0xFF.
- **Glitch.** Drive `uart_rxd` low for 3 clocks, then high → busy rises, returns to IDLE after the START decision, and no `uart_done`/`frame_err` occurs.
- **Framing error.** Send 0x3C with the stop bit low, then hold the line low for 40 bit periods → exactly one `frame_err` pulse and `uart_data` unchanged. After the line goes high, 0x3C is received correctly.
- **Reset mid-frame.** Assert `rst_n`=0 for 1 clock during data bit 4 → all outputs return to reset values and no pulse occurs; the next frame, 0x5A, is received correctly.
- **Majority vote (macro defined).** Send 0x81 with a 1-clock inverted spike at MID of bit 0 → `uart_data`=0x81. With the macro undefined, the same stimulus gives `uart_data`=0x80.
